// File: rtl/apb3_initiator.sv
// APB3 initiator: turns a single-command request port into one APB3 transfer
// (IDLE -> SETUP -> ACCESS -> RESP) with an optional wait-state timeout.
module apb3_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [31:0]           REQ_WDATA,
  output logic                  RSP_VALID,
  output logic [31:0]           RSP_RDATA,
  output logic                  RSP_ERR,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [8:0] TO_LIMIT = 9'(TIMEOUT);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       ready_en;
  logic       accept;
  logic       timeout_hit;

  // Handshake: a command is taken on a clock edge where REQ_VALID and
  // REQ_READY are both high; REQ_READY is only ever high in IDLE.
  assign accept = (state == IDLE) && ready_en && REQ_VALID;

  // Fires on the ACCESS cycle that would be the TIMEOUT-th PREADY-low cycle;
  // a PREADY-high cycle never times out, so normal completion wins.
  assign timeout_hit = (TIMEOUT != 0) && !PREADY &&
                       (({1'b0, wait_cnt} + 9'd1) == TO_LIMIT);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    REQ_READY = (state == IDLE) && ready_en;
    PSEL      = (state == SETUP) || (state == ACCESS);
    PENABLE   = (state == ACCESS);
    RSP_VALID = (state == RESP);
    dbg_state = state;
  end

  // ready_en keeps REQ_READY low while in reset and for no longer.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ready_en  <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= 32'h0;
      wait_cnt  <= 8'h0;
      RSP_RDATA <= 32'h0;
      RSP_ERR   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        PADDR  <= REQ_ADDR;
        PWRITE <= REQ_WRITE;
        PWDATA <= REQ_WDATA;
      end
      if (state == SETUP)
        wait_cnt <= 8'h0;
      else if ((state == ACCESS) && !PREADY && (wait_cnt != 8'hff))
        wait_cnt <= wait_cnt + 8'd1;
      if ((state == ACCESS) && PREADY) begin
        RSP_RDATA <= PWRITE ? 32'h0 : PRDATA;
        RSP_ERR   <= PSLVERR;
      end else if ((state == ACCESS) && timeout_hit) begin
        RSP_RDATA <= 32'h0;
        RSP_ERR   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb3_initiator.sv
// Bench for apb3_initiator: directed scenarios plus randomized transfers,
// each predicted from transfer-level rules (latency, data, error, timeout).
module tb_apb3_initiator;

  localparam int AW = 32;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          REQ_VALID;
  logic          REQ_READY;
  logic          REQ_WRITE;
  logic [AW-1:0] REQ_ADDR;
  logic [31:0]   REQ_WDATA;
  logic          RSP_VALID;
  logic [31:0]   RSP_RDATA;
  logic          RSP_ERR;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [31:0]   PWDATA;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [1:0]    dbg_state;

  apb3_initiator #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // observations of the last transfer, relative to the accept cycle
  int          obs_acc;
  int          obs_rsp_k;
  int          obs_psel_k;
  int          obs_pen_k;
  int          obs_viol;
  logic [31:0] obs_rdata;
  logic        obs_err;

  // reference: a transfer with `waits` PREADY-low cycles completes normally
  // if waits < TO, otherwise aborts after TO low cycles
  function automatic void model(input logic wr, input logic [31:0] prd,
                                input logic slverr, input int waits,
                                output int rsp_k, output logic [31:0] rdata,
                                output logic err);
    if (waits < TO) begin
      rsp_k = waits + 3;
      rdata = wr ? 32'h0 : prd;
      err   = slverr;
    end else begin
      rsp_k = TO + 2;
      rdata = 32'h0;
      err   = 1'b1;
    end
  endfunction

  // driver: issues one command (called at a negedge, returns at a negedge in
  // the IDLE cycle after the response) and plays a slave with `waits` waits
  task automatic do_txn(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] prd,
                        input logic slverr, input int waits, input logic hold);
    int  access_idx;
    bit  done;
    obs_acc = -1; obs_rsp_k = -1; obs_psel_k = -1; obs_pen_k = -1;
    obs_viol = 0; access_idx = 0; done = 0;
    REQ_VALID = 1'b1; REQ_WRITE = wr; REQ_ADDR = addr; REQ_WDATA = wdata;
    for (int i = 0; i < 20; i++) begin
      if (REQ_READY === 1'b1) begin
        obs_acc = cyc;
        break;
      end
      @(negedge PCLK);
    end
    if (obs_acc < 0) begin
      REQ_VALID = 1'b0;
      return;
    end
    @(negedge PCLK);
    if (hold) begin
      REQ_WRITE = 1'($urandom); REQ_ADDR = $urandom; REQ_WDATA = $urandom;
    end else begin
      REQ_VALID = 1'b0;
    end
    for (int k = 1; k < 300 && !done; k++) begin
      if (PENABLE === 1'b1 && PSEL !== 1'b1) obs_viol++;
      if (PSEL === 1'b1 && (PADDR !== addr || PWRITE !== wr || PWDATA !== wdata))
        obs_viol++;
      if (PSEL === 1'b1 && obs_psel_k < 0) obs_psel_k = k;
      if (PENABLE === 1'b1 && obs_pen_k < 0) obs_pen_k = k;
      if (obs_rsp_k < 0) begin
        if (REQ_READY !== 1'b0) obs_viol++;
        if (RSP_VALID === 1'b1) begin
          obs_rsp_k = k; obs_rdata = RSP_RDATA; obs_err = RSP_ERR;
          if (PSEL !== 1'b0 || PENABLE !== 1'b0) obs_viol++;
        end
      end else begin
        if (RSP_VALID !== 1'b0 || PSEL !== 1'b0 || REQ_READY !== 1'b1 ||
            RSP_RDATA !== obs_rdata || RSP_ERR !== obs_err) obs_viol++;
        done = 1;
      end
      if (PSEL === 1'b1 && PENABLE === 1'b1) begin
        access_idx++;
        PREADY = (access_idx > waits);
      end else begin
        PREADY = 1'($urandom);
      end
      if (PSEL === 1'b1 && PENABLE === 1'b1 && PREADY) begin
        PRDATA = prd; PSLVERR = slverr;
      end else begin
        PRDATA = $urandom; PSLVERR = 1'($urandom);
      end
      if (!done) @(negedge PCLK);
    end
  endtask

  task automatic test_reset();
    if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PWRITE !== 1'b0) begin
      bad++; $display("FAIL reset_apb_ctl psel=%b penable=%b pwrite=%b want 0 0 0", PSEL, PENABLE, PWRITE);
    end
    total++;
    if (PADDR !== '0 || PWDATA !== 32'h0) begin
      bad++; $display("FAIL reset_apb_data paddr=%h pwdata=%h want 0 0", PADDR, PWDATA);
    end
    total++;
    if (REQ_READY !== 1'b0 || RSP_VALID !== 1'b0 || RSP_RDATA !== 32'h0 || RSP_ERR !== 1'b0) begin
      bad++; $display("FAIL reset_rsp ready=%b valid=%b rdata=%h err=%b want all 0", REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR);
    end
    total++;
    PRESET = 1'b0;
    #1;
    if (REQ_READY !== 1'b0) begin
      bad++; $display("FAIL ready_before_edge got=%b want 0", REQ_READY);
    end
    total++;
    @(negedge PCLK);
    if (REQ_READY !== 1'b1) begin
      bad++; $display("FAIL ready_after_edge got=%b want 1", REQ_READY);
    end
    total++;
  endtask

  task automatic test_zero_wait_read();
    do_txn(1'b0, 32'h40, $urandom, 32'hDEADBEEF, 1'b0, 0, 1'b0);
    if (obs_psel_k !== 1 || obs_pen_k !== 2 || obs_rsp_k !== 3) begin
      bad++; $display("FAIL zw_timing psel@%0d penable@%0d rsp@%0d want 1 2 3", obs_psel_k, obs_pen_k, obs_rsp_k);
    end
    total++;
    if (obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0) begin
      bad++; $display("FAIL zw_data rdata=%h err=%b want deadbeef 0", obs_rdata, obs_err);
    end
    total++;
    if (obs_viol !== 0) begin
      bad++; $display("FAIL zw_protocol violations=%0d want 0", obs_viol);
    end
    total++;
  endtask

  task automatic test_write_waits();
    do_txn(1'b1, 32'h0000_1230, 32'h12345678, $urandom, 1'b0, 3, 1'b0);
    if (obs_rsp_k !== 6 || obs_rdata !== 32'h0 || obs_err !== 1'b0) begin
      bad++; $display("FAIL wr3_rsp rsp@%0d rdata=%h err=%b want 6 0 0", obs_rsp_k, obs_rdata, obs_err);
    end
    total++;
    if (obs_viol !== 0) begin
      bad++; $display("FAIL wr3_stable violations=%0d want 0", obs_viol);
    end
    total++;
  endtask

  task automatic test_slave_err();
    logic [31:0] prd;
    prd = $urandom;
    do_txn(1'b0, 32'h0000_0080, $urandom, prd, 1'b1, 1, 1'b0);
    if (obs_rsp_k !== 4 || obs_rdata !== prd || obs_err !== 1'b1) begin
      bad++; $display("FAIL slverr rsp@%0d rdata=%h err=%b want 4 %h 1", obs_rsp_k, obs_rdata, obs_err, prd);
    end
    total++;
    repeat (3) @(negedge PCLK);
    if (RSP_RDATA !== prd || RSP_ERR !== 1'b1) begin
      bad++; $display("FAIL rsp_hold rdata=%h err=%b want %h 1", RSP_RDATA, RSP_ERR, prd);
    end
    total++;
  endtask

  task automatic test_timeout();
    logic [31:0] prd;
    logic        e;
    do_txn(1'b0, 32'h0000_0100, $urandom, $urandom, 1'b0, 1000, 1'b0);
    if (obs_rsp_k !== TO + 2 || obs_rdata !== 32'h0 || obs_err !== 1'b1) begin
      bad++; $display("FAIL timeout rsp@%0d rdata=%h err=%b want %0d 0 1", obs_rsp_k, obs_rdata, obs_err, TO + 2);
    end
    total++;
    if (obs_viol !== 0) begin
      bad++; $display("FAIL timeout_psel violations=%0d want 0", obs_viol);
    end
    total++;
    prd = $urandom;
    e   = 1'($urandom);
    do_txn(1'b0, 32'h0000_0104, $urandom, prd, e, TO - 1, 1'b0);
    if (obs_rsp_k !== TO + 2 || obs_rdata !== prd || obs_err !== e) begin
      bad++; $display("FAIL timeout_edge rsp@%0d rdata=%h err=%b want %0d %h %b", obs_rsp_k, obs_rdata, obs_err, TO + 2, prd, e);
    end
    total++;
  endtask

  task automatic test_reset_mid();
    int seen;
    bit acc;
    seen = 0; acc = 0;
    REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 32'h200; REQ_WDATA = $urandom;
    PREADY = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (REQ_READY === 1'b1) acc = 1;
      @(negedge PCLK);
    end
    REQ_VALID = 1'b0;
    @(negedge PCLK);
    if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
      bad++; $display("FAIL rst_mid_access psel=%b penable=%b want 1 1", PSEL, PENABLE);
    end
    total++;
    #2 PRESET = 1'b1;
    #1;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin
      bad++; $display("FAIL rst_mid_drop psel=%b penable=%b want 0 0", PSEL, PENABLE);
    end
    total++;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) PRESET = 1'b0;
      PREADY = 1'b1;
      if (RSP_VALID === 1'b1) seen++;
      @(negedge PCLK);
    end
    if (seen !== 0) begin
      bad++; $display("FAIL rst_mid_norsp rsp_valid_cycles=%0d want 0", seen);
    end
    total++;
    do_txn(1'b0, 32'h204, $urandom, 32'h0BADF00D, 1'b0, 0, 1'b0);
    if (obs_rsp_k !== 3 || obs_rdata !== 32'h0BADF00D || obs_err !== 1'b0 || obs_viol !== 0) begin
      bad++; $display("FAIL rst_mid_after rsp@%0d rdata=%h err=%b viol=%0d want 3 0badf00d 0 0", obs_rsp_k, obs_rdata, obs_err, obs_viol);
    end
    total++;
  endtask

  task automatic test_back_to_back();
    int a0;
    int v0;
    do_txn(1'b1, 32'h300, 32'hA5A5A5A5, $urandom, 1'b0, 0, 1'b1);
    a0 = obs_acc; v0 = obs_viol;
    do_txn(1'b0, 32'h304, $urandom, 32'h5A5A5A5A, 1'b0, 0, 1'b0);
    if (a0 < 0 || obs_acc - a0 !== 4) begin
      bad++; $display("FAIL b2b_gap accepts at %0d and %0d want gap 4", a0, obs_acc);
    end
    total++;
    if (v0 !== 0 || obs_viol !== 0 || obs_rdata !== 32'h5A5A5A5A) begin
      bad++; $display("FAIL b2b_xfer viol=%0d/%0d rdata=%h want 0/0 5a5a5a5a", v0, obs_viol, obs_rdata);
    end
    total++;
  endtask

  task automatic test_random();
    logic        wr;
    logic        e;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] prd;
    logic [31:0] exp_rd;
    logic [31:0] exp_d;
    logic        exp_e;
    int          w;
    int          exp_k;
    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom); e = 1'($urandom); addr = $urandom; wd = $urandom;
      prd = $urandom; w = $urandom_range(0, TO + 1);
      model(wr, prd, e, w, exp_k, exp_d, exp_e);
      exp_q.push_back(exp_d);
      do_txn(wr, addr, wd, prd, e, w, 1'b0);
      exp_rd = exp_q.pop_front();
      if (obs_rsp_k !== exp_k || obs_rdata !== exp_rd || obs_err !== exp_e || obs_viol !== 0) begin
        bad++;
        $display("FAIL rand_%0d wr=%b waits=%0d rsp@%0d rdata=%h err=%b viol=%0d want %0d %h %b 0",
                 n, wr, w, obs_rsp_k, obs_rdata, obs_err, obs_viol, exp_k, exp_rd, exp_e);
      end
      total++;
      if ($urandom_range(0, 1) == 1) @(negedge PCLK);
    end
  endtask

  initial begin
    PRESET = 1'b1; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = '0;
    REQ_WDATA = 32'h0; PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    test_reset();
    test_zero_wait_read();
    test_write_waits();
    test_slave_err();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb3_initiator.md
APB3_INITIATOR -- requirements
Module: apb3_initiator

Interface
REQ-001 Parameters (name, default, meaning):
- ADDR_WIDTH, 32, width of REQ_ADDR and PADDR.
- TIMEOUT, 16, maximum number of PREADY-low ACCESS cycles before abort; legal range 0..255; 0 disables the timeout.

REQ-002 Ports (name, direction, width, meaning):
- PCLK, in, 1, the single clock.
- PRESET, in, 1, asynchronous active-high reset.
- REQ_VALID, in, 1, command request.
- REQ_READY, out, 1, command accepted when high with REQ_VALID.
- REQ_WRITE, in, 1, 1 = write, 0 = read.
- REQ_ADDR, in, ADDR_WIDTH, command address.
- REQ_WDATA, in, 32, write data.
- RSP_VALID, out, 1, one-cycle completion pulse.
- RSP_RDATA, out, 32, read data.
- RSP_ERR, out, 1, completion error.
- PADDR, out, ADDR_WIDTH, APB3 address.
- PSEL, out, 1, APB3 select.
- PENABLE, out, 1, APB3 enable.
- PWRITE, out, 1, APB3 direction.
- PWDATA, out, 32, APB3 write data.
- PRDATA, in, 32, APB3 read data.
- PREADY, in, 1, APB3 ready.
- PSLVERR, in, 1, APB3 error.

REQ-003 The interface SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-004 The block SHALL implement an FSM with the states IDLE, SETUP, ACCESS and RESP.
REQ-005 All outputs SHALL be registered, or decoded directly from registered state; there SHALL be no combinational path from the APB inputs to the APB outputs.
REQ-006 IDLE behaviour:
- REQ_READY = 1, PSEL = 0, PENABLE = 0.
- On REQ_VALID, capture REQ_WRITE, REQ_ADDR and REQ_WDATA, then go to SETUP.
REQ-007 REQ_READY SHALL be 0 in every state other than IDLE; REQ_VALID outside IDLE SHALL be ignored.
REQ-008 SETUP behaviour:
- Exactly one cycle with PSEL = 1, PENABLE = 0.
- PADDR, PWRITE and PWDATA driven from the captured values.
- Then go to ACCESS.
REQ-009 ACCESS behaviour: PSEL = 1 and PENABLE = 1; PADDR, PWRITE and PWDATA SHALL remain stable.
REQ-010 Normal completion: in ACCESS with PREADY = 1, go to RESP.
- RSP_RDATA = PRDATA for reads, 32'h0 for writes.
- RSP_ERR = PSLVERR.
REQ-011 Wait counter (8-bit):
- Cleared on entry to ACCESS.
- Increments on each ACCESS cycle with PREADY = 0.
REQ-012 Timeout: if TIMEOUT != 0 and the counter reaches TIMEOUT while PREADY = 0, go to RESP with RSP_ERR = 1 and RSP_RDATA = 32'h0.
- PSEL and PENABLE SHALL be 0 from the next cycle.
REQ-013 If PREADY = 1 in the same cycle the timeout would fire, normal completion (REQ-010) SHALL take priority.
REQ-014 RESP behaviour:
- RSP_VALID = 1 for exactly one cycle; PSEL = 0, PENABLE = 0.
- Then go to IDLE.
- No response backpressure exists.
REQ-015 Zero-wait latency:
- Accept at cycle N, SETUP at N+1, ACCESS at N+2, RSP_VALID at N+3.
- Next accept no earlier than N+4.
REQ-016 PSLVERR and PRDATA SHALL be sampled only in an ACCESS cycle with PREADY = 1 and ignored at all other times.
REQ-017 RSP_RDATA and RSP_ERR SHALL hold their last values until the next completion.
REQ-018 PENABLE SHALL never be 1 while PSEL is 0.

Reset
REQ-019 While PRESET = 1, the block SHALL hold these values:
- State IDLE.
- PSEL = 0, PENABLE = 0, PWRITE = 0.
- PADDR = 0, PWDATA = 0.
- REQ_READY = 0, RSP_VALID = 0, RSP_RDATA = 0, RSP_ERR = 0.
- Wait counter = 0.
REQ-020 Reset assertion mid-transfer SHALL drop PSEL and PENABLE asynchronously, generate no RSP_VALID, and discard the captured command.
REQ-021 REQ_READY SHALL become 1 on the first PCLK edge after PRESET deasserts.

Verification
REQ-022 Zero-wait read: addr 0x40, PRDATA = 0xDEADBEEF, PREADY = 1 -> PSEL at N+1, PENABLE at N+2, RSP_VALID at N+3 with RSP_RDATA = 0xDEADBEEF, RSP_ERR = 0.
REQ-023 Write, 3 wait states: data 0x12345678, PREADY low for 3 ACCESS cycles -> PWDATA and PADDR stable throughout, RSP_VALID at N+6, RSP_RDATA = 0, RSP_ERR = 0.
REQ-024 Slave error: read with PSLVERR = 1 and PREADY = 1 -> RSP_ERR = 1, RSP_RDATA = PRDATA.
REQ-025 Timeout, TIMEOUT = 4, PREADY held 0 -> RSP_VALID with RSP_ERR = 1 after 4 wait cycles, PSEL = 0 afterwards; a second run with PREADY = 1 on the 4th wait cycle -> normal completion, RSP_ERR = PSLVERR.
REQ-026 Reset in ACCESS: PRESET pulsed -> PSEL and PENABLE = 0 immediately, no RSP_VALID; a new request after release completes normally.
REQ-027 Back-to-back: REQ_VALID held high for 2 commands -> second accepted exactly 4 cycles after the first; REQ_READY low during SETUP, ACCESS and RESP.
